matrix_frame_scheduler: RTL and testbench

Frame scheduler for the 8x8 LED matrix. It steps through glyphs held in an external font ROM and holds each glyph for a programmable number of frames. Each frame is streamed to the LED strip serializer as 64 ordered pixel bits over a valid/ready handshake, with the row-serpentine reordering the physical strip wiring requires. It sits between the font ROM and the serializer, which generates the strip start/end frames and the per-LED colour words.

---
 rtl/matrix_frame_scheduler.sv | 157 +++++++++++++++
 tb/tb_matrix_frame_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_scheduler.sv
// Glyph frame scheduler for the 8x8 LED matrix: loads font ROM glyphs and streams 64 pixel bits per frame.
// Optional feature: define MATRIX_SERPENTINE_EN for zig-zag strip order (even rows reversed).
module matrix_frame_scheduler #(
    parameter int unsigned NUM_GLYPHS   = 26,
    parameter int unsigned DWELL_FRAMES = 16,
    parameter int unsigned FRAME_GAP    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [4:0]  font_idx,
    input  logic [63:0] font_bits,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_on,
    output logic        pix_first,
    output logic        pix_last,
    output logic [15:0] frame_count,
    output logic        busy
);
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned POS_W = 6;
    localparam int unsigned PIX_N = 64;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_GLYPHS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(FRAME_GAP - 1);
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(PIX_N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             r_state,       w_state_nxt;
    logic [PIX_N-1:0]   r_frame,       w_frame_nxt;
    logic [POS_W-1:0]   r_p,           w_p_nxt;
    logic [CNT_W-1:0]   r_gap,         w_gap_nxt;
    logic [CNT_W-1:0]   r_dwell,       w_dwell_nxt;
    logic               r_adv,         w_adv_nxt;
    logic [IDX_W-1:0]   r_font_idx,    w_font_idx_nxt;
    logic [CNT_W-1:0]   r_frame_count, w_frame_count_nxt;
    logic               r_pix_valid,   w_pix_valid_nxt;
    logic               r_pix_on,      w_pix_on_nxt;
    logic               r_pix_first,   w_pix_first_nxt;
    logic               r_pix_last,    w_pix_last_nxt;
    logic               r_busy,        w_busy_nxt;
    logic [POS_W-1:0]   w_k;

    // Next-state, sequencing and next-output logic; outputs are registered from these values.
    always_comb begin
        w_state_nxt       = r_state;
        w_frame_nxt       = r_frame;
        w_p_nxt           = r_p;
        w_gap_nxt         = r_gap;
        w_dwell_nxt       = r_dwell;
        w_adv_nxt         = r_adv;
        w_font_idx_nxt    = r_font_idx;
        w_frame_count_nxt = r_frame_count;

        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_frame_nxt = font_bits;
                w_p_nxt     = '0;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (pix_ready) begin
                    w_p_nxt = r_p + POS_W'(1);
                    if (r_p == POS_LAST) begin
                        w_state_nxt       = S_GAP;
                        w_gap_nxt         = '0;
                        w_frame_count_nxt = r_frame_count + CNT_W'(1);
                        if (r_dwell == DWELL_LAST) begin
                            w_dwell_nxt = '0;
                            w_adv_nxt   = 1'b1;
                        end else begin
                            w_dwell_nxt = r_dwell + CNT_W'(1);
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    // Glyph advance is deferred to here so the ROM settles a cycle before LOAD.
                    if (r_adv) begin
                        w_font_idx_nxt = (r_font_idx == IDX_LAST) ? '0 : r_font_idx + IDX_W'(1);
                        w_adv_nxt      = 1'b0;
                    end
                    w_state_nxt = enable ? S_LOAD : S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

`ifdef MATRIX_SERPENTINE_EN
        w_k = w_p_nxt[3] ? w_p_nxt : {w_p_nxt[5:3], ~w_p_nxt[2:0]};
`else
        w_k = w_p_nxt;
`endif
        w_pix_valid_nxt = (w_state_nxt == S_STREAM);
        w_pix_on_nxt    = w_pix_valid_nxt && w_frame_nxt[POS_LAST - w_k];
        w_pix_first_nxt = w_pix_valid_nxt && (w_p_nxt == '0);
        w_pix_last_nxt  = w_pix_valid_nxt && (w_p_nxt == POS_LAST);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_frame       <= '0;
            r_p           <= '0;
            r_gap         <= '0;
            r_dwell       <= '0;
            r_adv         <= 1'b0;
            r_font_idx    <= '0;
            r_frame_count <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_on      <= 1'b0;
            r_pix_first   <= 1'b0;
            r_pix_last    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame       <= w_frame_nxt;
            r_p           <= w_p_nxt;
            r_gap         <= w_gap_nxt;
            r_dwell       <= w_dwell_nxt;
            r_adv         <= w_adv_nxt;
            r_font_idx    <= w_font_idx_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_pix_valid   <= w_pix_valid_nxt;
            r_pix_on      <= w_pix_on_nxt;
            r_pix_first   <= w_pix_first_nxt;
            r_pix_last    <= w_pix_last_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign font_idx    = r_font_idx;
    assign pix_valid   = r_pix_valid;
    assign pix_on      = r_pix_on;
    assign pix_first   = r_pix_first;
    assign pix_last    = r_pix_last;
    assign frame_count = r_frame_count;
    assign busy        = r_busy;

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Self-checking bench for matrix_frame_scheduler: directed frame table plus randomized run against a pixel-order model.
// Honours MATRIX_SERPENTINE_EN the same way the design does.
module tb_matrix_frame_scheduler;
    localparam int unsigned NG    = 3;
    localparam int unsigned DWELL = 2;
    localparam int unsigned GAP   = 8;
    localparam int          BUDGET = 5000;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [4:0]  font_idx;
    logic [63:0] font_bits;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_on;
    logic        pix_first;
    logic        pix_last;
    logic [15:0] frame_count;
    logic        busy;

    matrix_frame_scheduler #(
        .NUM_GLYPHS  (NG),
        .DWELL_FRAMES(DWELL),
        .FRAME_GAP   (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .font_idx   (font_idx),
        .font_bits  (font_bits),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_on     (pix_on),
        .pix_first  (pix_first),
        .pix_last   (pix_last),
        .frame_count(frame_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Font ROM model, with an override used by the directed frame table.
    logic [63:0] rom [32];
    logic        ovr_en;
    logic [63:0] ovr_val;
    assign font_bits = ovr_en ? ovr_val : rom[font_idx];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          model_frames;
    int          pos;
    int          vcnt;
    int          busy_cycles;
    int          frame_xfers;
    bit          pend_fc;
    bit          prev_stall;
    logic [2:0]  prev_outs;
    logic [63:0] cur_mask;
    int          idx_log [8];
    int          log_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int strip_to_bit(input int p);
        int r;
        int c;
        r = p / 8;
        c = p % 8;
`ifdef MATRIX_SERPENTINE_EN
        if (r % 2 == 0) return r * 8 + (7 - c);
`endif
        return p;
    endfunction

    function automatic int model_idx();
        return (model_frames / DWELL) % NG;
    endfunction

    task automatic model_reset();
        model_frames = 0;
        pos          = 0;
        vcnt         = 0;
        pend_fc      = 0;
        prev_stall   = 0;
        prev_outs    = '0;
        log_n        = 0;
    endtask

    // One cycle: drive pix_ready for the coming edge and check what the DUT offers.
    // mode 0: ready always, 1: stall on odd valid cycles, 2: random.
    task automatic step(input int mode);
        bit          rdy;
        logic [63:0] bits;
        int          k;
        @(negedge clk);
        if (pend_fc) begin
            chk("frame_count", 64'(frame_count), 64'(model_frames % 65536));
            pend_fc = 0;
        end
        if (pix_valid) vcnt++;
        case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (vcnt % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        pix_ready = rdy;
        if (busy) busy_cycles++;
        if (prev_stall) begin
            chk("stall_valid", 64'(pix_valid), 64'(1));
            chk("stall_hold", 64'({pix_on, pix_first, pix_last}), 64'(prev_outs));
        end
        prev_stall = pix_valid && !pix_ready;
        prev_outs  = {pix_on, pix_first, pix_last};
        if (pix_valid && pix_ready) begin
            bits = ovr_en ? ovr_val : rom[model_idx()];
            k    = strip_to_bit(pos);
            chk("pix_on", 64'(pix_on), 64'(bits[63-k]));
            chk("pix_first", 64'(pix_first), 64'(pos == 0));
            chk("pix_last", 64'(pix_last), 64'(pos == 63));
            chk("font_idx", 64'(font_idx), 64'(model_idx()));
            if (pos == 0 && log_n < 8) begin
                idx_log[log_n] = int'(font_idx);
                log_n++;
            end
            if (pix_on) cur_mask[pos] = 1'b1;
            frame_xfers++;
            pos++;
            if (pos == 64) begin
                pos = 0;
                vcnt = 0;
                model_frames++;
                pend_fc = 1;
            end
        end
    endtask

    task automatic wait_idle(input int mode);
        int b;
        b = 0;
        while (busy && b < BUDGET) begin
            step(mode);
            b++;
        end
        chk("idle_reached", 64'(busy), 64'(0));
    endtask

    task automatic run_frames(input int n, input int mode);
        int target;
        int b;
        target = model_frames + n;
        b = 0;
        enable = 1'b1;
        while (model_frames < target && b < BUDGET) begin
            step(mode);
            b++;
        end
        chk("frames_done", 64'(model_frames >= target), 64'(1));
        enable = 1'b0;
        wait_idle(mode);
    endtask

    typedef struct {
        logic [63:0] bits;
        int          mode;
        logic [63:0] exp_mask;
        int          exp_busy;
    } vec_t;

    vec_t vecs [6];
    int   exp_seq [7];

    initial begin
        vecs[0] = '{64'h8000_0000_0000_0001, 0, 64'h8000_0000_0000_0001, 1 + 64 + GAP};
        vecs[1] = '{64'hFF00_0000_0000_0000, 1, 64'h0000_0000_0000_00FF, 1 + 128 + GAP};
        vecs[2] = '{64'h0100_0000_0000_0000, 0, 64'h0000_0000_0000_0080, 1 + 64 + GAP};
        vecs[3] = '{64'h0080_0000_0000_0000, 1, 64'h0000_0000_0000_0100, 1 + 128 + GAP};
        vecs[4] = '{64'h0000_0000_0000_8000, 0, 64'h0001_0000_0000_0000, 1 + 64 + GAP};
        vecs[5] = '{64'h8000_0000_0000_0001, 1, 64'h8000_0000_0000_0001, 1 + 128 + GAP};
`ifdef MATRIX_SERPENTINE_EN
        vecs[0].exp_mask = 64'h8000_0000_0000_0080;
        vecs[2].exp_mask = 64'h0000_0000_0000_0001;
        vecs[4].exp_mask = 64'h0080_0000_0000_0000;
        vecs[5].exp_mask = 64'h8000_0000_0000_0080;
`endif
        exp_seq = '{0, 0, 1, 1, 2, 2, 0};

        for (int i = 0; i < 32; i++) rom[i] = {$urandom, $urandom};
        ovr_en = 1'b0;
        ovr_val = '0;
        enable = 1'b0;
        pix_ready = 1'b0;
        cur_mask = '0;
        busy_cycles = 0;
        frame_xfers = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset and idle
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 10 == 0)
                chk("idle_outputs", 64'({font_idx, pix_valid, pix_on, pix_first, pix_last, frame_count, busy}), 64'(0));
        end

        // Glyph sequencing across 7 frames with random backpressure
        run_frames(7, 2);
        for (int i = 0; i < 7; i++) chk($sformatf("glyph_seq[%0d]", i), 64'(idx_log[i]), 64'(exp_seq[i]));

        // Directed single frames
        for (int v = 0; v < 6; v++) begin
            ovr_en = 1'b1;
            ovr_val = vecs[v].bits;
            cur_mask = '0;
            busy_cycles = 0;
            frame_xfers = 0;
            enable = 1'b1;
            step(vecs[v].mode);
            chk($sformatf("load_valid[%0d]", v), 64'(pix_valid), 64'(0));
            chk($sformatf("load_busy[%0d]", v), 64'(busy), 64'(1));
            enable = 1'b0;
            step(vecs[v].mode);
            chk($sformatf("first_valid[%0d]", v), 64'(pix_valid), 64'(1));
            wait_idle(vecs[v].mode);
            chk($sformatf("mask[%0d]", v), cur_mask, vecs[v].exp_mask);
            chk($sformatf("busy_cycles[%0d]", v), 64'(busy_cycles), 64'(vecs[v].exp_busy));
            chk($sformatf("xfers[%0d]", v), 64'(frame_xfers), 64'(64));
            ovr_en = 1'b0;
        end

        // Enable drop mid-frame: frame and gap complete, then idle
        begin
            int b;
            int f0;
            f0 = model_frames;
            b = 0;
            enable = 1'b1;
            while (pos != 20 && b < BUDGET) begin
                step(2);
                b++;
            end
            enable = 1'b0;
            wait_idle(2);
            chk("drop_frame_done", 64'(model_frames), 64'(f0 + 1));
            chk("drop_valid", 64'(pix_valid), 64'(0));
            repeat (5) step(0);
            chk("drop_stays_idle", 64'(busy), 64'(0));
            run_frames(1, 0);
        end

        // Asynchronous reset at p=40
        begin
            int b;
            b = 0;
            enable = 1'b1;
            while (pos != 40 && b < BUDGET) begin
                step(0);
                b++;
            end
            #2 rst_n = 1'b0;
            #1;
            chk("rst_valid", 64'(pix_valid), 64'(0));
            chk("rst_outputs", 64'({font_idx, pix_on, pix_first, pix_last, frame_count, busy}), 64'(0));
            enable = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            repeat (4) step(0);
            chk("post_rst_idx", 64'(font_idx), 64'(0));
            chk("post_rst_fc", 64'(frame_count), 64'(0));
            chk("post_rst_busy", 64'(busy), 64'(0));
            run_frames(1, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
